// File: rtl/mips_pkg.sv
// Shared MIPS datapath types: multiply/divide opcodes and the mult/div FSM states.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_t;

endpackage

// File: rtl/abs_neg32.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix-up.
module abs_neg32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; WIDTH+2 cycles start-to-done.
import mips_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_rs;
    logic               r_is_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_dz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    md_op_t             w_op;
    logic               w_signed;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_rs_mag;
    logic [WIDTH-1:0]   w_rt_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_lo_fix;
    logic [WIDTH-1:0]   w_hi_neg;
    logic [WIDTH-1:0]   w_hi_fix;

    assign w_op     = md_op_t'(op);
    assign w_signed = (w_op == MD_MULT) || (w_op == MD_DIV);
    assign w_is_div = (w_op == MD_DIV) || (w_op == MD_DIVU);

    abs_neg32 #(.WIDTH(WIDTH)) u_abs_rs (
        .i_val (rs_data),
        .i_neg (w_signed & rs_data[WIDTH-1]),
        .o_val (w_rs_mag)
    );

    abs_neg32 #(.WIDTH(WIDTH)) u_abs_rt (
        .i_val (rt_data),
        .i_neg (w_signed & rt_data[WIDTH-1]),
        .o_val (w_rt_mag)
    );

    // Multiply: accumulator low half holds the multiplier and drains right as the product fills in.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // Divide: restoring step; partial remainder may need WIDTH+1 bits after the shift.
    assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};
    assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    abs_neg32 #(.WIDTH(WIDTH)) u_fix_lo (
        .i_val (r_acc[WIDTH-1:0]),
        .i_neg (r_neg_res),
        .o_val (w_lo_fix)
    );

    abs_neg32 #(.WIDTH(WIDTH)) u_fix_hi (
        .i_val (r_acc[2*WIDTH-1:WIDTH]),
        .i_neg (r_is_div ? r_neg_rem : r_neg_res),
        .o_val (w_hi_neg)
    );

    // A 2*WIDTH negate only carries into the high half when the low half is zero.
    assign w_hi_fix = (!r_is_div && r_neg_res && (r_acc[WIDTH-1:0] != '0))
                      ? ~r_acc[2*WIDTH-1:WIDTH] : w_hi_neg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_rs      <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (hi_we) r_hi <= wdata;
                    if (lo_we) r_lo <= wdata;
                    if (start) begin
                        r_is_div  <= w_is_div;
                        r_b       <= w_is_div ? w_rt_mag : w_rs_mag;
                        r_acc     <= {{WIDTH{1'b0}}, (w_is_div ? w_rs_mag : w_rt_mag)};
                        r_neg_res <= w_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        r_neg_rem <= w_signed & rs_data[WIDTH-1];
                        r_dz      <= w_is_div & (rt_data == '0);
                        r_rs      <= rs_data;
                        r_cnt     <= '0;
                        r_dbz     <= 1'b0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH-1)) r_state <= FIX;
                end
                FIX: begin
                    r_hi    <= r_dz ? r_rs : w_hi_fix;
                    r_lo    <= r_dz ? '1   : w_lo_fix;
                    r_dbz   <= r_dz;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomized checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain integer arithmetic.
    task automatic model(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] e_hi, output logic [31:0] e_lo, output logic e_dz);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        e_dz = 1'b0;
        sa   = int'(a);
        sb   = int'(b);
        case (m_op)
            2'd0: begin
                sp   = longint'(sa) * longint'(sb);
                up   = 64'(sp);
                e_hi = up[63:32];
                e_lo = up[31:0];
            end
            2'd1: begin
                up   = {32'd0, a} * {32'd0, b};
                e_hi = up[63:32];
                e_lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e_lo = 32'hFFFF_FFFF;
                    e_hi = a;
                    e_dz = 1'b1;
                end else if (m_op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e_lo = 32'h8000_0000;
                    e_hi = 32'd0;
                end else if (m_op == 2'd2) begin
                    e_lo = 32'(sa / sb);
                    e_hi = 32'(sa % sb);
                end else begin
                    e_lo = a / b;
                    e_hi = a % b;
                end
            end
        endcase
    endtask

    task automatic launch(input logic [1:0] m_op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op      = m_op;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called right after launch; counts edges from the start edge up to the done cycle.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 1;
        busy_cnt = 0;
        while (edges < 100) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cnt++;
            @(posedge clk);
            edges++;
        end
        if (edges >= 100) check("done_timeout", 64'(edges), 64'd34);
    endtask

    task automatic run_and_check(input string tag, input logic [1:0] m_op,
                                 input logic [31:0] a, input logic [31:0] b);
        int          edges;
        int          bcnt;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_dz;
        model(m_op, a, b, e_hi, e_lo, e_dz);
        launch(m_op, a, b);
        wait_done(edges, bcnt);
        check({tag, "_latency"}, 64'(edges), 64'd34);
        check({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        check({tag, "_hi"}, 64'(hi), 64'(e_hi));
        check({tag, "_lo"}, 64'(lo), 64'(e_lo));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(e_dz));
    endtask

    initial begin
        int          edges;
        int          bcnt;
        int          seen_done;
        logic [1:0]  r_op;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b0; start = 1'b0; op = 2'd0; rs_data = '0; rt_data = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b1;

        run_and_check("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_max_lo_const", 64'(lo), 64'h0000_0000_0000_0001);
        run_and_check("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFEB);
        run_and_check("divu_100_7", 2'd3, 32'd100, 32'd7);
        check("divu_lo_const", 64'(lo), 64'd14);
        run_and_check("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_neg_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        run_and_check("div_zero", 2'd2, 32'h1234_5678, 32'd0);
        check("div_zero_flag_const", 64'(div_by_zero), 64'd1);
        run_and_check("divu_zero", 2'd3, 32'hDEAD_BEEF, 32'd0);
        run_and_check("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo_const", 64'(lo), 64'h0000_0000_8000_0000);

        // Start and MTHI while busy must both be dropped.
        launch(2'd1, 32'd2, 32'd3);
        repeat (5) @(posedge clk);
        @(negedge clk);
        op = 2'd3; rs_data = 32'd9; rt_data = 32'd3; start = 1'b1;
        hi_we = 1'b1; wdata = 32'h0000_AAAA;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        edges = 0;
        while (!done && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check("busy_ign_done", 64'(done), 64'd1);
        check("busy_ign_hi", 64'(hi), 64'd0);
        check("busy_ign_lo", 64'(lo), 64'd6);
        @(negedge clk);
        check("busy_ign_no_restart", 64'(busy), 64'd0);

        lo_we = 1'b1; wdata = 32'h55;
        @(negedge clk);
        lo_we = 1'b0;
        check("mtlo", 64'(lo), 64'h55);
        check("mtlo_hi_kept", 64'(hi), 64'd0);

        // MTHI alongside start lands first, then the result overwrites it.
        @(negedge clk);
        op = 2'd1; rs_data = 32'd6; rt_data = 32'd7; start = 1'b1;
        hi_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1 start = 1'b0; hi_we = 1'b0;
        @(negedge clk);
        check("mthi_with_start", 64'(hi), 64'h0BAD_F00D);
        wait_done(edges, bcnt);
        check("mthi_overwritten_hi", 64'(hi), 64'd0);
        check("mthi_overwritten_lo", 64'(lo), 64'd42);

        // Reset mid-RUN aborts with no done pulse.
        launch(2'd2, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        rst = 1'b1;
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);

        run_and_check("after_rst", 2'd1, 32'd4, 32'd5);

        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                4: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_and_check("rand", r_op, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
